// File: rtl/fc_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_tx_scheduler
// Summary  : Round-robin whole-frame scheduler in front of the FC framer
//            user-TX port, gated by BB credit, inter-frame gap and link state.
// Revision : 1.0  initial release
// ============================================================================
module fc_tx_scheduler #(
    parameter int NUM_REQ   = 2,
    parameter int IFG_WORDS = 6,
    parameter int BB_CREDIT = 8,
    parameter int CREDIT_W  = 8,
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    link_active_i,
    input  logic                    rrdy_pulse_i,
    input  logic [32*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_sop_i,
    input  logic [NUM_REQ-1:0]      req_eop_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [31:0]             tx_data_o,
    output logic                    tx_valid_o,
    output logic                    tx_sop_o,
    output logic                    tx_eop_o,
    input  logic                    tx_ready_i,
    output logic [CREDIT_W-1:0]     credit_avail_o,
    output logic [IDX_W-1:0]        grant_idx_o,
    output logic [31:0]             frames_sent_o,
    output logic [15:0]             frames_abort_o,
    output logic                    credit_error_o
);

    localparam int GAP_W = (IFG_WORDS > 2) ? $clog2(IFG_WORDS) : 1;
    localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'(IFG_WORDS - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(BB_CREDIT);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_REQ - 1);
    localparam bit                  SKIP_GAP   = (IFG_WORDS <= 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [31:0]           sent_q, sent_d;
    logic [15:0]           abort_q, abort_d;
    logic                  cerr_q, cerr_d;

    logic [NUM_REQ-1:0]    cand_w;
    logic [NUM_REQ-1:0]    req_ready_w;
    logic [IDX_W-1:0]      pick_w;
    logic                  pick_found_w;
    logic                  grant_fire_w;
    logic                  g_valid_w, g_sop_w, g_eop_w;
    logic [31:0]           g_data_w;
    logic                  xfer_valid_w;
    logic                  sop_acc_w;
    logic                  eop_acc_w;

    assign cand_w    = req_valid_i & req_sop_i;
    assign g_valid_w = req_valid_i[grant_q];
    assign g_sop_w   = req_sop_i[grant_q];
    assign g_eop_w   = req_eop_i[grant_q];
    assign g_data_w  = req_data_i[32*grant_q +: 32];

    // Round-robin scan beginning one past the last granted requester.
    always_comb begin
        logic [IDX_W-1:0] scan;
        pick_found_w = 1'b0;
        pick_w       = grant_q;
        scan         = grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (scan == IDX_LAST) ? '0 : scan + 1'b1;
            if (!pick_found_w && cand_w[scan]) begin
                pick_found_w = 1'b1;
                pick_w       = scan;
            end
        end
    end

    assign grant_fire_w = (state_q == ST_ARB) && pick_found_w &&
                          link_active_i && (credit_q != '0);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gap_d        = gap_q;
        sent_d       = sent_q;
        abort_d      = abort_q;
        xfer_valid_w = 1'b0;
        req_ready_w  = '0;
        sop_acc_w    = 1'b0;
        eop_acc_w    = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (grant_fire_w) begin
                    grant_d = pick_w;
                    state_d = ST_XFER;
                end else begin
                    req_ready_w = req_valid_i & ~req_sop_i;
                end
            end
            ST_XFER: begin
                if (link_active_i) begin
                    xfer_valid_w         = g_valid_w;
                    req_ready_w[grant_q] = tx_ready_i;
                    sop_acc_w            = g_valid_w & tx_ready_i & g_sop_w;
                    eop_acc_w            = g_valid_w & tx_ready_i & g_eop_w;
                    if (eop_acc_w) begin
                        sent_d  = sent_q + 32'd1;
                        gap_d   = GAP_LOAD;
                        state_d = SKIP_GAP ? ST_ARB : ST_GAP;
                    end
                end else begin
                    state_d = ST_DRAIN;
                    if (abort_q != '1) begin
                        abort_d = abort_q + 16'd1;
                    end
                end
            end
            ST_DRAIN: begin
                req_ready_w[grant_q] = 1'b1;
                if (g_valid_w && g_eop_w) begin
                    gap_d   = GAP_LOAD;
                    state_d = SKIP_GAP ? ST_ARB : ST_GAP;
                end
            end
            ST_GAP: begin
                // The ARB cycle that follows is the final idle word of the gap.
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        cerr_d   = cerr_q;
        if (sop_acc_w && !rrdy_pulse_i) begin
            credit_d = credit_q - 1'b1;
        end else if (!sop_acc_w && rrdy_pulse_i) begin
            if (credit_q >= CREDIT_MAX) begin
                cerr_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_ARB;
            grant_q  <= IDX_LAST;
            credit_q <= CREDIT_MAX;
            gap_q    <= '0;
            sent_q   <= '0;
            abort_q  <= '0;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            gap_q    <= gap_d;
            sent_q   <= sent_d;
            abort_q  <= abort_d;
            cerr_q   <= cerr_d;
        end
    end

    // Handshake outputs are forced low directly by reset, without a clock edge.
    always_comb begin
        req_ready_o = '0;
        tx_valid_o  = 1'b0;
        tx_sop_o    = 1'b0;
        tx_eop_o    = 1'b0;
        tx_data_o   = '0;
        if (!reset_i) begin
            req_ready_o = req_ready_w;
            if (state_q == ST_XFER) begin
                tx_valid_o = xfer_valid_w;
                tx_sop_o   = xfer_valid_w & g_sop_w;
                tx_eop_o   = xfer_valid_w & g_eop_w;
                tx_data_o  = g_data_w;
            end
        end
    end

    assign credit_avail_o = credit_q;
    assign grant_idx_o    = grant_q;
    assign frames_sent_o  = sent_q;
    assign frames_abort_o = abort_q;
    assign credit_error_o = cerr_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_tx_scheduler
// Summary  : Directed self-checking bench for fc_tx_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_fc_tx_scheduler;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } beat_t;

    typedef struct packed {
        int          c;
        logic [31:0] d;
        logic        s;
        logic        e;
    } logent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        link;
    logic        rrdy;
    logic        rrdy2;
    logic [63:0] req_data;
    logic [1:0]  req_valid, req_sop, req_eop, req_ready;
    logic [31:0] tx_data;
    logic        tx_valid, tx_sop, tx_eop, tx_ready;
    logic [7:0]  credit;
    logic [0:0]  grant;
    logic [31:0] sent;
    logic [15:0] abort_cnt;
    logic        cerr;

    logic [63:0] req2_data;
    logic [1:0]  req2_valid, req2_sop, req2_eop, req2_ready;
    logic [31:0] tx2_data;
    logic        tx2_valid, tx2_sop, tx2_eop, tx2_ready;
    logic [7:0]  credit2;
    logic [0:0]  grant2;
    logic [31:0] sent2;
    logic [15:0] abort2;
    logic        cerr2;

    fc_tx_scheduler u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .link_active_i  (link),
        .rrdy_pulse_i   (rrdy),
        .req_data_i     (req_data),
        .req_valid_i    (req_valid),
        .req_sop_i      (req_sop),
        .req_eop_i      (req_eop),
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_sop_o       (tx_sop),
        .tx_eop_o       (tx_eop),
        .tx_ready_i     (tx_ready),
        .credit_avail_o (credit),
        .grant_idx_o    (grant),
        .frames_sent_o  (sent),
        .frames_abort_o (abort_cnt),
        .credit_error_o (cerr)
    );

    fc_tx_scheduler #(.BB_CREDIT(2)) u_dut2 (
        .clk_i          (clk),
        .reset_i        (reset),
        .link_active_i  (link),
        .rrdy_pulse_i   (rrdy2),
        .req_data_i     (req2_data),
        .req_valid_i    (req2_valid),
        .req_sop_i      (req2_sop),
        .req_eop_i      (req2_eop),
        .req_ready_o    (req2_ready),
        .tx_data_o      (tx2_data),
        .tx_valid_o     (tx2_valid),
        .tx_sop_o       (tx2_sop),
        .tx_eop_o       (tx2_eop),
        .tx_ready_i     (tx2_ready),
        .credit_avail_o (credit2),
        .grant_idx_o    (grant2),
        .frames_sent_o  (sent2),
        .frames_abort_o (abort2),
        .credit_error_o (cerr2)
    );

    beat_t   qa[$];
    beat_t   qb[$];
    beat_t   qc[$];
    logent_t txlog[$];
    int      cyc     = 0;
    int      vectors = 0;
    int      errs    = 0;
    int      g0, nlog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_heads();
        req_valid  = '0; req_sop  = '0; req_eop  = '0; req_data  = '0;
        req2_valid = '0; req2_sop = '0; req2_eop = '0; req2_data = '0;
        if (qa.size() > 0) begin
            req_valid[0] = 1'b1; req_sop[0] = qa[0].s; req_eop[0] = qa[0].e;
            req_data[31:0] = qa[0].d;
        end
        if (qb.size() > 0) begin
            req_valid[1] = 1'b1; req_sop[1] = qb[0].s; req_eop[1] = qb[0].e;
            req_data[63:32] = qb[0].d;
        end
        if (qc.size() > 0) begin
            req2_valid[0] = 1'b1; req2_sop[0] = qc[0].s; req2_eop[0] = qc[0].e;
            req2_data[31:0] = qc[0].d;
        end
    endtask

    task automatic settle();
        drive_heads();
        #1;
    endtask

    task automatic tick();
        logic    aa, ab, ac;
        logent_t le;
        @(negedge clk);
        aa = req_valid[0] & req_ready[0];
        ab = req_valid[1] & req_ready[1];
        ac = req2_valid[0] & req2_ready[0];
        if (tx_valid && tx_ready) begin
            le.c = cyc; le.d = tx_data; le.s = tx_sop; le.e = tx_eop;
            txlog.push_back(le);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (aa) void'(qa.pop_front());
        if (ab) void'(qb.pop_front());
        if (ac) void'(qc.pop_front());
        drive_heads();
    endtask

    task automatic push_frame(input int which, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.d = base + 32'(i);
            b.s = (i == 0);
            b.e = (i == n - 1);
            if (which == 0)      qa.push_back(b);
            else if (which == 1) qb.push_back(b);
            else                 qc.push_back(b);
        end
    endtask

    task automatic wait_sof(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!seen && tx_valid && tx_sop && tx_ready) seen = 1'b1;
            if (!seen) tick();
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; link = 1'b1; rrdy = 1'b0; rrdy2 = 1'b0;
        tx_ready = 1'b1; tx2_ready = 1'b1;
        drive_heads();
        repeat (3) tick();

        // Reset values, with frames already waiting at both requesters.
        push_frame(0, 32'hA000_0000, 3);
        push_frame(1, 32'hB000_0000, 3);
        settle();
        chk("rst_credit", 32'(credit), 32'd8);
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_sent", sent, 32'd0);
        chk("rst_abort", 32'(abort_cnt), 32'd0);
        chk("rst_cerr", 32'(cerr), 32'd0);
        chk("rst_txvalid", 32'(tx_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Test 1: two 3-beat frames, round-robin order and inter-frame gap.
        reset = 1'b0;
        #1;
        g0 = cyc;
        chk("t1_grantcyc_txvalid", 32'(tx_valid), 32'd0);
        chk("t1_grantcyc_ready", 32'(req_ready), 32'd0);
        repeat (16) tick();
        chk("t1_nbeats", 32'(txlog.size()), 32'd6);
        chk("t1_first_data", txlog[0].d, 32'hA000_0000);
        chk("t1_first_lat", 32'(txlog[0].c), 32'(g0 + 1));
        chk("t1_eof", 32'(txlog[2].e), 32'd1);
        chk("t1_second_data", txlog[3].d, 32'hB000_0000);
        chk("t1_ifg", 32'(txlog[3].c - txlog[2].c), 32'd7);
        chk("t1_sent", sent, 32'd2);
        chk("t1_credit", 32'(credit), 32'd6);
        chk("t1_grant", 32'(grant), 32'd1);

        // Test 3: single-beat frame, then SOP accept coinciding with R_RDY.
        push_frame(0, 32'hC000_0000, 1);
        settle();
        repeat (10) tick();
        chk("t3_single_credit", 32'(credit), 32'd5);
        chk("t3_single_sent", sent, 32'd3);
        chk("t3_single_se", {30'd0, txlog[6].s, txlog[6].e}, 32'd3);
        push_frame(1, 32'hD000_0000, 2);
        push_frame(0, 32'hE000_0000, 2);
        settle();
        wait_sof("t3_sof_wait");
        chk("t3_rr_pick", tx_data, 32'hD000_0000);
        rrdy = 1'b1;
        tick();
        rrdy = 1'b0;
        chk("t3_sop_rrdy_credit", 32'(credit), 32'd5);
        repeat (20) tick();
        chk("t3_after_e_credit", 32'(credit), 32'd4);
        chk("t3_after_e_sent", sent, 32'd5);
        for (int i = 0; i < 4; i++) begin
            rrdy = 1'b1; tick();
            rrdy = 1'b0; tick();
        end
        chk("t3_refill_credit", 32'(credit), 32'd8);
        chk("t3_refill_cerr", 32'(cerr), 32'd0);
        rrdy = 1'b1; tick();
        rrdy = 1'b0; tick();
        chk("t3_over_credit", 32'(credit), 32'd8);
        chk("t3_over_cerr", 32'(cerr), 32'd1);

        // Test 4: link drop after two accepted beats of a 5-beat frame.
        push_frame(0, 32'hF000_0000, 5);
        settle();
        wait_sof("t4_sof_wait");
        tick();
        tick();
        nlog = txlog.size();
        link = 1'b0;
        #1;
        chk("t4_drop_txvalid", 32'(tx_valid), 32'd0);
        chk("t4_drop_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t4_abort_cnt", 32'(abort_cnt), 32'd1);
        chk("t4_drain_ready", 32'(req_ready[0]), 32'd1);
        chk("t4_drain_txvalid", 32'(tx_valid), 32'd0);
        repeat (3) tick();
        chk("t4_drained", 32'(qa.size()), 32'd0);
        chk("t4_no_tx", 32'(txlog.size()), 32'(nlog));
        chk("t4_credit", 32'(credit), 32'd7);
        chk("t4_sent", sent, 32'd5);
        link = 1'b1;
        repeat (8) tick();

        // Test 5: headless beat flushed in ARB, then backpressured frame.
        push_frame(1, 32'h5555_0001, 1);
        qb[0].s = 1'b0;
        qb[0].e = 1'b0;
        settle();
        chk("t5_flush_ready", 32'(req_ready[1]), 32'd1);
        chk("t5_flush_txvalid", 32'(tx_valid), 32'd0);
        nlog = txlog.size();
        tick();
        chk("t5_flush_gone", 32'(qb.size()), 32'd0);
        chk("t5_flush_no_tx", 32'(txlog.size()), 32'(nlog));
        push_frame(1, 32'h6000_0000, 4);
        settle();
        for (int i = 0; i < 16; i++) begin
            tx_ready = ((i % 3) != 1);
            tick();
        end
        tx_ready = 1'b1;
        repeat (8) tick();
        chk("t5_bp_count", 32'(txlog.size()), 32'(nlog + 4));
        for (int i = 0; i < 4; i++) begin
            chk("t5_bp_seq", txlog[nlog + i].d, 32'h6000_0000 + 32'(i));
        end
        chk("t5_bp_sop", 32'(txlog[nlog].s), 32'd1);
        chk("t5_bp_eop", 32'(txlog[nlog + 3].e), 32'd1);
        chk("t5_bp_sent", sent, 32'd6);

        // Test 6: asynchronous reset in the middle of a frame.
        push_frame(0, 32'h7000_0000, 4);
        settle();
        wait_sof("t6_sof_wait");
        tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_txvalid", 32'(tx_valid), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_txdata", tx_data, 32'd0);
        chk("t6_rst_txsop", 32'(tx_sop), 32'd0);
        chk("t6_rst_credit", 32'(credit), 32'd8);
        chk("t6_rst_grant", 32'(grant), 32'd1);
        tick();
        reset = 1'b0;
        qa.delete();
        settle();
        push_frame(1, 32'h8000_0000, 1);
        settle();
        tick();
        chk("t6_arb_sof", {30'd0, tx_valid, tx_sop}, 32'd3);
        chk("t6_arb_data", tx_data, 32'h8000_0000);
        repeat (8) tick();
        chk("t6_credit", 32'(credit), 32'd7);

        // Test 2: credit-starved instance with BB_CREDIT=2.
        for (int i = 0; i < 4; i++) push_frame(2, 32'h9000_0000 + 32'(16 * i), 2);
        settle();
        repeat (40) tick();
        chk("t2_sent", sent2, 32'd2);
        chk("t2_credit", 32'(credit2), 32'd0);
        chk("t2_left", 32'(qc.size()), 32'd4);
        chk("t2_stall_txvalid", 32'(tx2_valid), 32'd0);
        rrdy2 = 1'b1;
        tick();
        rrdy2 = 1'b0;
        repeat (20) tick();
        chk("t2_sent_after", sent2, 32'd3);
        chk("t2_credit_after", 32'(credit2), 32'd0);
        chk("t2_left_after", 32'(qc.size()), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
